// File: rtl/data_mem_ls.sv
// data_mem_ls: RV32I B/H/W data memory, big-endian lanes; define DMEM_MISALIGN_TRAP_EN to trap misaligned H/W.
// Response pulses LATENCY+1 cycles after accept; req_ready stays low from accept through the response cycle.
module data_mem_ls #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        l_we;
    logic [2:0]  l_f3;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;

    logic [31:0] mem [DEPTH];

    logic [AW-1:0] idx;
    logic          illegal;
    logic          oor;
    logic          misal;
    logic          acc_err;
    logic [1:0]    size;
    logic [1:0]    lane_sh;
    logic [4:0]    shamt;
    logic [3:0]    mask;
    logic [3:0]    wr_mask;
    logic [31:0]   cur;
    logic [31:0]   lane;
    logic [31:0]   wr_word;
    logic [31:0]   acc_rdata;
    logic          exec;

    assign idx  = l_addr[AW+1:2];
    assign exec = (state == BUSY) && (cnt == 4'd0);

    always_comb begin
        illegal   = 1'b0;
        size      = 2'd2;
        lane_sh   = 2'd0;
        mask      = 4'b1111;
        acc_rdata = '0;
        case (l_f3)
            3'b000, 3'b100: size = 2'd0;
            3'b001, 3'b101: size = 2'd1;
            3'b010:         size = 2'd2;
            default:        illegal = 1'b1;
        endcase
        if (l_we && l_f3[2])
            illegal = 1'b1;
        oor = (l_addr[31:2] >= 30'(DEPTH));
`ifdef DMEM_MISALIGN_TRAP_EN
        misal = ((size == 2'd1) && l_addr[0]) || ((size == 2'd2) && (l_addr[1:0] != 2'b00));
`else
        misal = 1'b0;
`endif
        acc_err = illegal || oor || misal;

        // Offset 0 is the MSB lane, so the shift counts lanes up from [7:0]; low bits of H/W are ignored.
        case (size)
            2'd0: begin
                lane_sh = ~l_addr[1:0];
                mask    = 4'b0001 << lane_sh;
            end
            2'd1: begin
                lane_sh = {~l_addr[1], 1'b0};
                mask    = 4'b0011 << lane_sh;
            end
            default: begin
                lane_sh = 2'd0;
                mask    = 4'b1111;
            end
        endcase
        shamt   = {lane_sh, 3'b000};
        cur     = mem[idx];
        lane    = cur >> shamt;
        wr_word = l_wdata << shamt;

        case (l_f3)
            3'b000:  acc_rdata = {{24{lane[7]}}, lane[7:0]};
            3'b100:  acc_rdata = {24'd0, lane[7:0]};
            3'b001:  acc_rdata = {{16{lane[15]}}, lane[15:0]};
            3'b101:  acc_rdata = {16'd0, lane[15:0]};
            default: acc_rdata = lane;
        endcase
        if (acc_err || l_we)
            acc_rdata = '0;
        wr_mask = (acc_err || !l_we) ? 4'b0000 : mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            cnt        <= '0;
            l_we       <= 1'b0;
            l_f3       <= '0;
            l_addr     <= '0;
            l_wdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        l_we      <= req_we;
                        l_f3      <= req_funct3;
                        l_addr    <= req_addr;
                        l_wdata   <= req_wdata;
                        cnt       <= 4'(LATENCY - 1);
                        req_ready <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= acc_rdata;
                        resp_err   <= acc_err;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The array has no reset; a reset landing on the execute edge must still suppress the write.
    always_ff @(posedge clk) begin
        if (exec && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i])
                    mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_ls.sv
// Bench for data_mem_ls: byte-array reference model checked every cycle plus directed literal checks.
module tb_data_mem_ls;
    localparam int DEPTH   = 64;
    localparam int LATENCY = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int vectors = 0;
    int miscompares = 0;

    data_mem_ls #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference memory: big-endian byte array, byte address a holds lane a%4 counted from the MSB.
    logic [7:0] mb [DEPTH*4];

    task automatic model_exec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic err, output logic [31:0] rd);
        int n;
        logic [31:0] a;
        logic [31:0] v;
        logic misal;
        n   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        err = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
        err = err || (addr[31:2] >= DEPTH);
        misal = (addr % n) != 0;
`ifdef DMEM_MISALIGN_TRAP_EN
        err = err || misal;
`endif
        a  = addr - (addr % n);
        rd = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < n; i++)
                    mb[a + i] = wdata[8*(n-1-i) +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++)
                    v = (v << 8) | 32'(mb[a + i]);
                if (n == 1)      rd = f3[2] ? v : {{24{v[7]}}, v[7:0]};
                else if (n == 2) rd = f3[2] ? v : {{16{v[15]}}, v[15:0]};
                else             rd = v;
            end
        end
    endtask

    // Per-cycle compare process: predicts handshake timing and held response values.
    initial begin : cmp
        int cyc;
        int resp_cyc;
        bit pend;
        logic p_we;
        logic [2:0] p_f3;
        logic [31:0] p_addr, p_wdata;
        logic h_err, exp_rdy, exp_vld;
        logic [31:0] h_rd;
        cyc = 0; resp_cyc = 0; pend = 0;
        p_we = 0; p_f3 = 0; p_addr = 0; p_wdata = 0;
        h_err = 0; h_rd = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                pend = 0; h_rd = 0; h_err = 0; exp_rdy = 1; exp_vld = 0;
            end else begin
                exp_vld = pend && (cyc == resp_cyc);
                exp_rdy = !(pend && (cyc <= resp_cyc));
                if (exp_vld) begin
                    model_exec(p_we, p_f3, p_addr, p_wdata, h_err, h_rd);
                    pend = 0;
                end
            end
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("resp_valid", 32'(resp_valid), 32'(exp_vld));
            chk("resp_rdata", resp_rdata, h_rd);
            chk("resp_err", 32'(resp_err), 32'(h_err));
            if (!rst && exp_rdy && req_valid) begin
                pend = 1; resp_cyc = cyc + LATENCY + 1;
                p_we = req_we; p_f3 = req_funct3; p_addr = req_addr; p_wdata = req_wdata;
            end
        end
    end

    task automatic wait_accept(input string nm);
        bit got = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (req_ready) begin got = 1; break; end
        end
        if (!got) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_resp(input string nm, output int lat);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (resp_valid) begin lat = k; break; end
        end
        if (lat < 0) chk({nm, "_resp_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit lit, input logic e_err,
                          input logic [31:0] e_rd, input string nm);
        int lat;
        @(posedge clk); #1;
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        wait_accept(nm);
        @(posedge clk); #1;
        req_valid = 0; req_we = $urandom; req_addr = $urandom; req_wdata = $urandom;
        wait_resp(nm, lat);
        if (lit && lat > 0) begin
            chk({nm, "_lat"}, 32'(lat), 32'(LATENCY + 1));
            chk({nm, "_err"}, 32'(resp_err), 32'(e_err));
            chk({nm, "_rdata"}, resp_rdata, e_rd);
        end
    endtask

    initial begin : drv
        int n, lat;
        logic [2:0] f3tab [8];
        f3tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        rst = 1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);

        for (int w = 0; w < DEPTH; w++)
            do_req(1, 3'b010, 32'(w * 4), $urandom, 0, 0, 0, "fill");

        do_req(1, 3'b010, 32'h8, 32'h11223344, 1, 0, 32'h0, "sw8");
        do_req(0, 3'b010, 32'h8, 32'h0, 1, 0, 32'h11223344, "lw8");

        // Reset landing in BUSY must drop the pending store.
        do_req(1, 3'b010, 32'h10, 32'hA5A5A5A5, 1, 0, 32'h0, "sw10");
        @(posedge clk); #1;
        req_valid = 1; req_we = 1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h5A5A5A5A;
        wait_accept("rst_busy");
        @(posedge clk); #1;
        req_valid = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        repeat (2) @(posedge clk);
        do_req(0, 3'b010, 32'h10, 32'h0, 1, 0, 32'hA5A5A5A5, "lw10_after_rst");

        do_req(1, 3'b010, 32'h0, 32'h0, 1, 0, 32'h0, "sw0");
        do_req(1, 3'b000, 32'h1, 32'hFF, 1, 0, 32'h0, "sb1");
        do_req(1, 3'b001, 32'h2, 32'h8001, 1, 0, 32'h0, "sh2");
        do_req(0, 3'b000, 32'h1, 32'h0, 1, 0, 32'hFFFFFFFF, "lb1");
        do_req(0, 3'b100, 32'h1, 32'h0, 1, 0, 32'h000000FF, "lbu1");
        do_req(0, 3'b001, 32'h2, 32'h0, 1, 0, 32'hFFFF8001, "lh2");
        do_req(0, 3'b101, 32'h2, 32'h0, 1, 0, 32'h00008001, "lhu2");
        do_req(0, 3'b010, 32'h0, 32'h0, 1, 0, 32'h00FF8001, "lw0");

        do_req(0, 3'b010, 32'h100, 32'h0, 1, 1, 32'h0, "lw_oor");
        do_req(1, 3'b010, 32'h100, 32'hDEADBEEF, 1, 1, 32'h0, "sw_oor");
        do_req(0, 3'b010, 32'h0, 32'h0, 1, 0, 32'h00FF8001, "lw0_after_oor");

        do_req(0, 3'b011, 32'h0, 32'h0, 1, 1, 32'h0, "f3_011");
        do_req(1, 3'b100, 32'h0, 32'h55, 1, 1, 32'h0, "sbu_illegal");
        do_req(0, 3'b010, 32'h0, 32'h0, 1, 0, 32'h00FF8001, "lw0_after_illegal");

        // Held request: second one must wait out BUSY and RESP of the first.
        @(posedge clk); #1;
        req_valid = 1; req_we = 1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
        wait_accept("b2b_first");
        @(posedge clk); #1;
        req_we = 0; req_wdata = 32'h0;
        n = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (req_ready) begin n = k; break; end
        end
        chk("b2b_spacing", 32'(n), 32'(LATENCY + 2));
        @(posedge clk); #1;
        req_valid = 0;
        wait_resp("b2b_second", lat);
        chk("b2b_rdata", resp_rdata, 32'hCAFEF00D);

`ifdef DMEM_MISALIGN_TRAP_EN
        do_req(0, 3'b001, 32'h3, 32'h0, 1, 1, 32'h0, "lh3_trap");
        do_req(1, 3'b010, 32'h5, 32'h13579BDF, 1, 1, 32'h0, "sw5_trap");
`else
        do_req(0, 3'b001, 32'h3, 32'h0, 1, 0, 32'hFFFF8001, "lh3_clear");
        do_req(1, 3'b010, 32'h5, 32'h13579BDF, 1, 0, 32'h0, "sw5_clear");
        do_req(0, 3'b010, 32'h4, 32'h0, 1, 0, 32'h13579BDF, "lw4");
`endif

        for (int t = 0; t < 200; t++) begin
            logic [2:0] f3;
            logic [31:0] a;
            n  = $urandom_range(0, 9);
            f3 = (n < 8) ? f3tab[n] : 3'b010;
            a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH*4 - 1));
            do_req(1'($urandom), f3, a, $urandom, 0, 0, 0, "rand");
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (10) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
